// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and line idle level.
// Used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } tx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, strobes bit_end_o on the
// last cycle of each bit and restarts; clr_i holds it at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_end_o = (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || bit_end_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter, 8N1 by default (start, 8 data LSB first, stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_dv_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_ready_o,
    output logic       tx_active_o,
    output logic       tx_serial_o,
    output logic       tx_done_o
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic       serial_q, serial_d;
    logic       bit_end;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_q == IDLE),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        unique case (state_q)
            IDLE: if (tx_dv_i) begin
                byte_d  = tx_byte_i;
                bit_d   = '0;
                state_d = START;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                if (bit_q == LAST_DATA) begin
                    bit_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) begin
                if (bit_q == LAST_STOP) begin
                    bit_d   = '0;
                    state_d = CLEANUP;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            CLEANUP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level is computed for the next state so the pin is a flop.
        serial_d = IDLE_LEVEL;
        case (state_d)
            START:   serial_d = ~IDLE_LEVEL;
            DATA:    serial_d = byte_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = ^byte_d;
`endif
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            byte_q   <= '0;
            serial_q <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            serial_q <= serial_d;
        end
    end

    assign tx_serial_o = serial_q;
    assign tx_ready_o  = (state_q == IDLE);
    assign tx_done_o   = (state_q == CLEANUP);
    assign tx_active_o = (state_q != IDLE) && (state_q != CLEANUP);

endmodule
